// File: rtl/app_mem_responder.sv
// ---------------------------------------------------------------------------
// app_mem_responder
//
// Synthesizable stand-in for the MIG user-interface (app_*) side. Accepts
// app commands and write-data beats, keeps data in a small internal RAM,
// returns read data after a fixed latency, and models both the calibration
// delay and pseudo-random app_rdy backpressure. It lets ddr_ctrl and the
// layers above it run in fast simulation without a PHY or memory model.
//
// Ports
//   ui_clk_i               UI clock
//   ui_rst_i               synchronous active-high reset
//   app_addr_i   [26:0]    byte-lane address, one 128-bit word = 8 addresses
//   app_cmd_i    [2:0]     3'b000 write, 3'b001 read, anything else illegal
//   app_en_i               command valid
//   app_wdf_data_i [127:0] write data beat
//   app_wdf_wren_i         write data valid
//   app_wdf_end_i          last beat, expected to equal app_wdf_wren_i
//   app_wdf_mask_i [15:0]  byte mask, 1 = byte not written
//   app_rdy_o              command accepted when app_en_i & app_rdy_o
//   app_wdf_rdy_o          beat accepted when app_wdf_wren_i & app_wdf_rdy_o
//   app_rd_data_o [127:0]  read data (zero while not valid)
//   app_rd_data_valid_o    one cycle per accepted read
//   app_rd_data_end_o      mirrors app_rd_data_valid_o
//   init_calib_complete_o  calibration done, sticky until reset
//   cmd_err_o              one-cycle pulse on illegal cmd or wren/end mismatch
// ---------------------------------------------------------------------------
module app_mem_responder #(
    parameter int          DEPTH_LOG2   = 6,
    parameter int          RD_LAT       = 4,
    parameter int          CALIB_CYCLES = 32,
    parameter int          STALL_EN     = 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic         ui_clk_i,
    input  logic         ui_rst_i,
    input  logic [26:0]  app_addr_i,
    input  logic [2:0]   app_cmd_i,
    input  logic         app_en_i,
    input  logic [127:0] app_wdf_data_i,
    input  logic         app_wdf_wren_i,
    input  logic         app_wdf_end_i,
    input  logic [15:0]  app_wdf_mask_i,
    output logic         app_rdy_o,
    output logic         app_wdf_rdy_o,
    output logic [127:0] app_rd_data_o,
    output logic         app_rd_data_valid_o,
    output logic         app_rd_data_end_o,
    output logic         init_calib_complete_o,
    output logic         cmd_err_o
);

    localparam int            DEPTH      = 1 << DEPTH_LOG2;
    localparam int            CW         = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
    localparam logic [CW-1:0] CALIB_LAST = CW'(CALIB_CYCLES - 1);
    localparam logic [15:0]   LFSR_TAPS  = 16'hB400; // x^16+x^14+x^13+x^11+1
    localparam logic          STALL_ON   = (STALL_EN != 0);

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [1:0] {
        ST_CALIB = 2'd0,
        ST_RUN   = 2'd1,
        ST_WPEND = 2'd2
    } state_t;

    // Right-shifting Galois LFSR step.
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Overlay the unmasked bytes of new_w onto old_w.
    function automatic logic [127:0] byte_merge(input logic [127:0] old_w,
                                                input logic [127:0] new_w,
                                                input logic [15:0]  mask);
        logic [127:0] res;
        res = old_w;
        for (int i = 0; i < 16; i++) begin
            if (!mask[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

    // ---------------- control state ----------------
    state_t                r_state;
    logic [CW-1:0]         r_calib_cnt;
    logic                  r_calib_done;
    logic [15:0]           r_lfsr;
    logic                  r_cmd_err;
    logic [2:0]            r_wdf_cnt;
    logic [1:0]            r_wdf_wp;
    logic [1:0]            r_wdf_rp;
    logic [RD_LAT-1:0]     r_rd_vld_p;

    // ---------------- data state (not reset) ----------------
    logic [127:0]          r_mem [DEPTH];
    logic [127:0]          r_wdf_data [4];
    logic [15:0]           r_wdf_mask [4];
    logic [DEPTH_LOG2-1:0] r_pend_idx;
    logic [127:0]          r_rd_data_p [RD_LAT];

    // ---------------- combinational decode ----------------
    logic                  w_stall;
    logic                  w_app_rdy;
    logic                  w_cmd_acc;
    logic                  w_wr_cmd;
    logic                  w_rd_cmd;
    logic                  w_bad_cmd;
    logic                  w_wdf_rdy;
    logic                  w_wdf_acc;
    logic                  w_fifo_ne;
    logic                  w_need_data;
    logic                  w_pop;
    logic                  w_bypass;
    logic                  w_commit;
    logic                  w_push;
    logic [DEPTH_LOG2-1:0] w_cmd_idx;
    logic [DEPTH_LOG2-1:0] w_wr_idx;
    logic [127:0]          w_wr_data;
    logic [15:0]           w_wr_mask;
    logic [127:0]          w_rd_word;
    logic                  w_unused_addr;

    assign w_stall   = STALL_ON & r_lfsr[0] & r_lfsr[3];
    assign w_app_rdy = (r_state == ST_RUN) & ~w_stall;
    assign w_cmd_acc = app_en_i & w_app_rdy;
    assign w_wr_cmd  = w_cmd_acc & (app_cmd_i == CMD_WR);
    assign w_rd_cmd  = w_cmd_acc & (app_cmd_i == CMD_RD);
    assign w_bad_cmd = w_cmd_acc & ~w_wr_cmd & ~w_rd_cmd;

    assign w_wdf_rdy = (r_wdf_cnt != 3'd4) & r_calib_done;
    assign w_wdf_acc = app_wdf_wren_i & w_wdf_rdy;
    assign w_fifo_ne = (r_wdf_cnt != 3'd0);

    // A write needs a beat either from a freshly accepted command or from the
    // command parked in WPEND. The FIFO head wins; an incoming beat is only
    // consumed directly when the FIFO is empty, so beat order is preserved.
    assign w_need_data = w_wr_cmd | (r_state == ST_WPEND);
    assign w_pop       = w_need_data & w_fifo_ne;
    assign w_bypass    = w_need_data & ~w_fifo_ne & w_wdf_acc;
    assign w_commit    = w_pop | w_bypass;
    assign w_push      = w_wdf_acc & ~w_bypass;

    // Upper address bits are dropped, so addresses alias onto the RAM.
    assign w_cmd_idx     = app_addr_i[DEPTH_LOG2+2:3];
    assign w_unused_addr = ^{app_addr_i[26:DEPTH_LOG2+3], app_addr_i[2:0]};

    assign w_wr_idx  = (r_state == ST_WPEND) ? r_pend_idx : w_cmd_idx;
    assign w_wr_data = w_pop ? r_wdf_data[r_wdf_rp] : app_wdf_data_i;
    assign w_wr_mask = w_pop ? r_wdf_mask[r_wdf_rp] : app_wdf_mask_i;

    // Write-first: a read sees a write committing to the same word this cycle.
    assign w_rd_word = (w_commit && (w_wr_idx == w_cmd_idx))
                     ? byte_merge(r_mem[w_cmd_idx], w_wr_data, w_wr_mask)
                     : r_mem[w_cmd_idx];

    // ---------------- control FSM, FIFO pointers, read valids ----------------
    always_ff @(posedge ui_clk_i) begin
        if (ui_rst_i) begin
            r_state      <= ST_CALIB;
            r_calib_cnt  <= '0;
            r_calib_done <= 1'b0;
            r_lfsr       <= LFSR_SEED;
            r_cmd_err    <= 1'b0;
            r_wdf_cnt    <= 3'd0;
            r_wdf_wp     <= 2'd0;
            r_wdf_rp     <= 2'd0;
            r_rd_vld_p   <= '0;
        end else begin
            unique case (r_state)
                ST_CALIB: begin
                    if (r_calib_cnt == CALIB_LAST) begin
                        r_state      <= ST_RUN;
                        r_calib_done <= 1'b1;
                    end else begin
                        r_calib_cnt <= r_calib_cnt + 1'b1;
                    end
                end
                ST_RUN: begin
                    r_lfsr <= lfsr_next(r_lfsr);
                    if (w_wr_cmd && !w_commit) r_state <= ST_WPEND;
                end
                ST_WPEND: begin
                    if (w_commit) r_state <= ST_RUN;
                end
                default: r_state <= ST_CALIB;
            endcase

            r_cmd_err <= w_bad_cmd | (app_wdf_wren_i ^ app_wdf_end_i);

            r_wdf_cnt <= r_wdf_cnt + {2'b00, w_push} - {2'b00, w_pop};
            if (w_push) r_wdf_wp <= r_wdf_wp + 2'd1;
            if (w_pop)  r_wdf_rp <= r_wdf_rp + 2'd1;

            // Stage 0 is loaded on read acceptance; stage RD_LAT-1 drives valid.
            r_rd_vld_p <= {r_rd_vld_p[RD_LAT-2:0], w_rd_cmd};
        end
    end

    // ---------------- RAM, FIFO storage, read data pipeline ----------------
    always_ff @(posedge ui_clk_i) begin
        if (w_commit) begin
            for (int i = 0; i < 16; i++) begin
                if (!w_wr_mask[i]) r_mem[w_wr_idx][8*i +: 8] <= w_wr_data[8*i +: 8];
            end
        end
        if (w_push) begin
            r_wdf_data[r_wdf_wp] <= app_wdf_data_i;
            r_wdf_mask[r_wdf_wp] <= app_wdf_mask_i;
        end
        // WPEND is only entered from a write command, and no command is
        // accepted while in WPEND, so capturing on every write is safe.
        if (w_wr_cmd) r_pend_idx <= w_cmd_idx;

        // ---- read pipeline stage 0 ----
        r_rd_data_p[0] <= w_rd_word;
        // ---- read pipeline stages 1 .. RD_LAT-1 ----
        for (int k = 1; k < RD_LAT; k++) begin
            r_rd_data_p[k] <= r_rd_data_p[k-1];
        end
    end

    assign app_rdy_o             = w_app_rdy;
    assign app_wdf_rdy_o         = w_wdf_rdy;
    assign app_rd_data_valid_o   = r_rd_vld_p[RD_LAT-1];
    assign app_rd_data_end_o     = r_rd_vld_p[RD_LAT-1];
    assign app_rd_data_o         = r_rd_vld_p[RD_LAT-1] ? r_rd_data_p[RD_LAT-1] : '0;
    assign init_calib_complete_o = r_calib_done;
    assign cmd_err_o             = r_cmd_err;

endmodule

// File: tb/tb_app_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_app_mem_responder
//
// Directed and randomized bench for app_mem_responder with default
// parameters (RD_LAT=4, CALIB_CYCLES=32, STALL_EN=1, seed 16'hACE1).
// Inputs are driven and outputs sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_app_mem_responder;

    localparam int RD_LAT = 4;

    logic         ui_clk_i = 1'b0;
    logic         ui_rst_i;
    logic [26:0]  app_addr_i;
    logic [2:0]   app_cmd_i;
    logic         app_en_i;
    logic [127:0] app_wdf_data_i;
    logic         app_wdf_wren_i;
    logic         app_wdf_end_i;
    logic [15:0]  app_wdf_mask_i;
    logic         app_rdy_o;
    logic         app_wdf_rdy_o;
    logic [127:0] app_rd_data_o;
    logic         app_rd_data_valid_o;
    logic         app_rd_data_end_o;
    logic         init_calib_complete_o;
    logic         cmd_err_o;

    app_mem_responder dut (
        .ui_clk_i              (ui_clk_i),
        .ui_rst_i              (ui_rst_i),
        .app_addr_i            (app_addr_i),
        .app_cmd_i             (app_cmd_i),
        .app_en_i              (app_en_i),
        .app_wdf_data_i        (app_wdf_data_i),
        .app_wdf_wren_i        (app_wdf_wren_i),
        .app_wdf_end_i         (app_wdf_end_i),
        .app_wdf_mask_i        (app_wdf_mask_i),
        .app_rdy_o             (app_rdy_o),
        .app_wdf_rdy_o         (app_wdf_rdy_o),
        .app_rd_data_o         (app_rd_data_o),
        .app_rd_data_valid_o   (app_rd_data_valid_o),
        .app_rd_data_end_o     (app_rd_data_end_o),
        .init_calib_complete_o (init_calib_complete_o),
        .cmd_err_o             (cmd_err_o)
    );

    always #5 ui_clk_i = ~ui_clk_i;

    int cyc = 0;
    always @(posedge ui_clk_i) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    // Every read-data beat, with the cycle it was seen in.
    logic [127:0] rd_q[$];
    int           rd_cyc_q[$];
    logic         rd_end_q[$];

    always @(negedge ui_clk_i) begin
        if (app_rd_data_valid_o === 1'b1) begin
            rd_q.push_back(app_rd_data_o);
            rd_cyc_q.push_back(cyc);
            rd_end_q.push_back(app_rd_data_end_o);
        end
    end

    function automatic logic [26:0] addr_of(input int idx);
        return 27'(idx * 8);
    endfunction

    task automatic clear_rd();
        rd_q.delete();
        rd_cyc_q.delete();
        rd_end_q.delete();
    endtask

    // Present a command at the current falling edge and hold it until taken.
    task automatic do_cmd(input logic [2:0] cmd, input logic [26:0] addr, output int acc_cyc);
        int n;
        n = 0;
        app_en_i   = 1'b1;
        app_cmd_i  = cmd;
        app_addr_i = addr;
        while (app_rdy_o !== 1'b1 && n < 200) begin
            @(negedge ui_clk_i);
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL cmd_accept_timeout: app_rdy_o=%b after %0d cycles, required 1", app_rdy_o, n);
        end
        acc_cyc = cyc;
        @(negedge ui_clk_i);
        app_en_i = 1'b0;
    endtask

    task automatic send_wdf(input logic [127:0] d, input logic [15:0] m);
        int n;
        n = 0;
        app_wdf_wren_i = 1'b1;
        app_wdf_end_i  = 1'b1;
        app_wdf_data_i = d;
        app_wdf_mask_i = m;
        while (app_wdf_rdy_o !== 1'b1 && n < 200) begin
            @(negedge ui_clk_i);
            n++;
        end
        if (n >= 200) begin
            failures++;
            $display("FAIL wdf_accept_timeout: app_wdf_rdy_o=%b, required 1", app_wdf_rdy_o);
        end
        @(negedge ui_clk_i);
        app_wdf_wren_i = 1'b0;
        app_wdf_end_i  = 1'b0;
    endtask

    task automatic do_write(input logic [26:0] addr, input logic [127:0] d, input logic [15:0] m);
        int acc;
        send_wdf(d, m);
        do_cmd(3'b000, addr, acc);
    endtask

    // Wait (bounded) for n beats, then a few extra cycles so stray beats show up.
    task automatic wait_rd(input int n);
        int t;
        t = 0;
        while (rd_q.size() < n && t < 300) begin
            @(negedge ui_clk_i);
            t++;
        end
        repeat (RD_LAT + 2) @(negedge ui_clk_i);
    endtask

    task automatic test_reset();
        int rel, t_init, t_rdy, t_wdf;
        ui_rst_i = 1'b1;
        repeat (3) @(negedge ui_clk_i);
        checks++;
        if ({app_rdy_o, app_wdf_rdy_o, app_rd_data_valid_o, app_rd_data_end_o,
             init_calib_complete_o, cmd_err_o} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl_outputs: got %b%b%b%b%b%b, required 000000", app_rdy_o,
                     app_wdf_rdy_o, app_rd_data_valid_o, app_rd_data_end_o,
                     init_calib_complete_o, cmd_err_o);
        end
        checks++;
        if (app_rd_data_o !== 128'h0) begin
            failures++;
            $display("FAIL reset_rd_data: got %h, required 0", app_rd_data_o);
        end
        ui_rst_i = 1'b0;
        rel = cyc;
        t_init = -1; t_rdy = -1; t_wdf = -1;
        for (int i = 0; i < 100; i++) begin
            @(negedge ui_clk_i);
            if (init_calib_complete_o === 1'b1 && t_init < 0) t_init = cyc - rel;
            if (app_rdy_o === 1'b1 && t_rdy < 0)              t_rdy  = cyc - rel;
            if (app_wdf_rdy_o === 1'b1 && t_wdf < 0)          t_wdf  = cyc - rel;
            if (t_init >= 0 && t_rdy >= 0 && t_wdf >= 0) break;
        end
        checks++;
        if (t_init != 32) begin
            failures++;
            $display("FAIL calib_delay: init_calib rose after %0d cycles, required 32", t_init);
        end
        checks++;
        if (t_rdy != 32) begin
            failures++;
            $display("FAIL calib_app_rdy: app_rdy rose after %0d cycles, required 32", t_rdy);
        end
        checks++;
        if (t_wdf != 32) begin
            failures++;
            $display("FAIL calib_wdf_rdy: app_wdf_rdy rose after %0d cycles, required 32", t_wdf);
        end
    endtask

    task automatic test_write_read();
        int acc;
        logic [127:0] d;
        d = 128'h0123456789ABCDEF0123456789ABCDEF;
        do_write(27'h000008, d, 16'h0000);
        clear_rd();
        do_cmd(3'b001, 27'h000008, acc);
        wait_rd(1);
        checks++;
        if (rd_q.size() != 1) begin
            failures++;
            $display("FAIL wr_rd_count: got %0d beats, required 1", rd_q.size());
        end else begin
            checks++;
            if (rd_q[0] !== d) begin
                failures++;
                $display("FAIL wr_rd_data: got %h, required %h", rd_q[0], d);
            end
            checks++;
            if (rd_cyc_q[0] - acc != 4) begin
                failures++;
                $display("FAIL wr_rd_latency: got %0d, required 4", rd_cyc_q[0] - acc);
            end
            checks++;
            if (rd_end_q[0] !== 1'b1) begin
                failures++;
                $display("FAIL wr_rd_end: got %b, required 1", rd_end_q[0]);
            end
        end
    endtask

    task automatic test_wpend();
        int acc;
        logic [127:0] d;
        d = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        do_cmd(3'b000, addr_of(2), acc);
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if (app_rdy_o !== 1'b0) begin
                failures++;
                $display("FAIL wpend_rdy_c%0d: app_rdy=%b, required 0", k, app_rdy_o);
            end
            if (k < 3) @(negedge ui_clk_i);
        end
        send_wdf(d, 16'h0000);
        clear_rd();
        do_cmd(3'b001, addr_of(2), acc);
        wait_rd(1);
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== d) begin
            failures++;
            $display("FAIL wpend_readback: beats=%0d data=%h, required 1 beat of %h",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 128'h0, d);
        end
    endtask

    task automatic test_masked();
        int acc;
        do_write(addr_of(3), {128{1'b1}}, 16'h0000);
        do_write(addr_of(3), 128'h0, 16'hFFFE);
        clear_rd();
        do_cmd(3'b001, addr_of(3), acc);
        wait_rd(1);
        checks++;
        if (rd_q.size() != 1 || rd_q[0] !== 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF00) begin
            failures++;
            $display("FAIL masked_write: beats=%0d data=%h, required ffff...ff00",
                     rd_q.size(), (rd_q.size() > 0) ? rd_q[0] : 128'h0);
        end
    endtask

    task automatic test_back_to_back();
        int acc[9];
        logic [127:0] exp_d[9];
        logic [127:0] a;
        a = 128'h55AA_1234_0F0F_F0F0_A5A5_5A5A_0001_0203;
        for (int i = 0; i < 8; i++) begin
            exp_d[i+1] = {4{8'(i), 24'h5AC3E1}};
            do_write(addr_of(8 + i), exp_d[i+1], 16'h0000);
        end
        exp_d[0] = a;
        send_wdf(a, 16'h0000);
        clear_rd();
        do_cmd(3'b000, addr_of(5), acc[0]);
        do_cmd(3'b001, addr_of(5), acc[0]);
        for (int i = 0; i < 8; i++) do_cmd(3'b001, addr_of(8 + i), acc[i+1]);
        wait_rd(9);
        checks++;
        if (rd_q.size() != 9) begin
            failures++;
            $display("FAIL b2b_count: got %0d beats, required 9", rd_q.size());
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (rd_q[i] !== exp_d[i] || rd_cyc_q[i] - acc[i] != 4 || rd_end_q[i] !== 1'b1) begin
                    failures++;
                    $display("FAIL b2b_read%0d: data=%h lat=%0d end=%b, required %h lat=4 end=1",
                             i, rd_q[i], rd_cyc_q[i] - acc[i], rd_end_q[i], exp_d[i]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        int acc;
        logic [127:0] f[4];
        for (int i = 0; i < 4; i++) begin
            f[i] = {32'hF1F0_0000 + 32'(i), 96'h0BAD_F00D_0000_1111_2222_3333};
            app_wdf_wren_i = 1'b1;
            app_wdf_end_i  = 1'b1;
            app_wdf_data_i = f[i];
            app_wdf_mask_i = 16'h0000;
            checks++;
            if (app_wdf_rdy_o !== 1'b1) begin
                failures++;
                $display("FAIL fifo_fill_rdy%0d: app_wdf_rdy=%b, required 1", i, app_wdf_rdy_o);
            end
            @(negedge ui_clk_i);
        end
        app_wdf_wren_i = 1'b0;
        app_wdf_end_i  = 1'b0;
        checks++;
        if (app_wdf_rdy_o !== 1'b0) begin
            failures++;
            $display("FAIL fifo_full_rdy: app_wdf_rdy=%b, required 0", app_wdf_rdy_o);
        end
        for (int i = 0; i < 4; i++) do_cmd(3'b000, addr_of(24 + i), acc);
        clear_rd();
        for (int i = 0; i < 4; i++) do_cmd(3'b001, addr_of(24 + i), acc);
        wait_rd(4);
        checks++;
        if (rd_q.size() != 4) begin
            failures++;
            $display("FAIL fifo_order_count: got %0d beats, required 4", rd_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_q[i] !== f[i]) begin
                    failures++;
                    $display("FAIL fifo_order%0d: got %h, required %h", i, rd_q[i], f[i]);
                end
            end
        end
    endtask

    task automatic test_illegal();
        int acc;
        logic [127:0] d2, d3;
        d2 = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
        d3 = 128'h7777_6666_5555_4444_3333_2222_1111_0000;
        do_cmd(3'b111, addr_of(2), acc);
        checks++;
        if (cmd_err_o !== 1'b1) begin
            failures++;
            $display("FAIL illegal_err_pulse: cmd_err=%b, required 1", cmd_err_o);
        end
        @(negedge ui_clk_i);
        checks++;
        if (cmd_err_o !== 1'b0) begin
            failures++;
            $display("FAIL illegal_err_clear: cmd_err=%b, required 0", cmd_err_o);
        end
        // wren without end: flagged, but the beat is still taken.
        app_wdf_wren_i = 1'b1;
        app_wdf_end_i  = 1'b0;
        app_wdf_data_i = d3;
        app_wdf_mask_i = 16'h0000;
        @(negedge ui_clk_i);
        app_wdf_wren_i = 1'b0;
        checks++;
        if (cmd_err_o !== 1'b1) begin
            failures++;
            $display("FAIL end_mismatch_err: cmd_err=%b, required 1", cmd_err_o);
        end
        do_cmd(3'b000, addr_of(20), acc);
        clear_rd();
        do_cmd(3'b001, addr_of(2), acc);
        do_cmd(3'b001, addr_of(20), acc);
        wait_rd(2);
        checks++;
        if (rd_q.size() != 2) begin
            failures++;
            $display("FAIL illegal_read_count: got %0d beats, required 2", rd_q.size());
        end else begin
            checks++;
            if (rd_q[0] !== d2) begin
                failures++;
                $display("FAIL illegal_ram_unchanged: got %h, required %h", rd_q[0], d2);
            end
            checks++;
            if (rd_q[1] !== d3) begin
                failures++;
                $display("FAIL end_mismatch_beat: got %h, required %h", rd_q[1], d3);
            end
        end
    endtask

    task automatic test_random();
        logic [127:0] model[64];
        logic [127:0] exp_q[$];
        int           acc_q[$];
        logic [127:0] d;
        logic [15:0]  m;
        logic [26:0]  a;
        int           idx, op, acc;
        for (int i = 0; i < 64; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            a = 27'($urandom);
            a[8:3] = 6'(i);
            do_write(a, d, 16'h0000);
            model[i] = d;
        end
        clear_rd();
        for (int k = 0; k < 1000; k++) begin
            op  = $urandom_range(0, 2);
            idx = $urandom_range(0, 63);
            a = 27'($urandom);
            a[8:3] = 6'(idx);
            d = {$urandom, $urandom, $urandom, $urandom};
            m = 16'($urandom);
            if (op == 2) begin
                do_cmd(3'b001, a, acc);
                exp_q.push_back(model[idx]);
                acc_q.push_back(acc);
            end else begin
                if (op == 0) begin
                    do_write(a, d, m);
                end else begin
                    do_cmd(3'b000, a, acc);
                    repeat ($urandom_range(0, 2)) @(negedge ui_clk_i);
                    send_wdf(d, m);
                end
                for (int b = 0; b < 16; b++)
                    if (!m[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            end
        end
        wait_rd(exp_q.size());
        checks++;
        if (rd_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rand_count: got %0d beats, required %0d", rd_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (rd_q[i] !== exp_q[i] || rd_cyc_q[i] - acc_q[i] != 4) begin
                    failures++;
                    $display("FAIL rand_read%0d: data=%h lat=%0d, required %h lat=4",
                             i, rd_q[i], rd_cyc_q[i] - acc_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall_duty();
        int hi;
        hi = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge ui_clk_i);
            if (app_rdy_o === 1'b1) hi++;
        end
        checks++;
        if (hi < 680 || hi > 820) begin
            failures++;
            $display("FAIL stall_duty: app_rdy high %0d of 1000 cycles, required 680..820", hi);
        end
    endtask

    task automatic test_reset_mid();
        int acc;
        clear_rd();
        do_cmd(3'b001, addr_of(3), acc);
        ui_rst_i = 1'b1;
        repeat (2) @(negedge ui_clk_i);
        checks++;
        if ({app_rdy_o, app_wdf_rdy_o, init_calib_complete_o, app_rd_data_valid_o} !== 4'b0) begin
            failures++;
            $display("FAIL midreset_outputs: rdy=%b wdf_rdy=%b calib=%b valid=%b, required 0",
                     app_rdy_o, app_wdf_rdy_o, init_calib_complete_o, app_rd_data_valid_o);
        end
        ui_rst_i = 1'b0;
        repeat (10) @(negedge ui_clk_i);
        checks++;
        if (rd_q.size() != 0) begin
            failures++;
            $display("FAIL midreset_flush: got %0d beats, required 0", rd_q.size());
        end
    endtask

    initial begin
        ui_rst_i       = 1'b1;
        app_addr_i     = '0;
        app_cmd_i      = 3'b000;
        app_en_i       = 1'b0;
        app_wdf_data_i = '0;
        app_wdf_wren_i = 1'b0;
        app_wdf_end_i  = 1'b0;
        app_wdf_mask_i = '0;
        @(negedge ui_clk_i);
        test_reset();
        test_write_read();
        test_wpend();
        test_masked();
        test_back_to_back();
        test_fifo_full();
        test_illegal();
        test_random();
        test_stall_duty();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
